// File: rtl/gba_vram_pkg.sv
// Shared types and constants for the VRAM background fetch path.
package gba_vram_pkg;

  localparam int MAP_UNIT_BYTES  = 2048;
  localparam int CHAR_UNIT_BYTES = 16384;
  localparam int TILE4_BYTES     = 32;

  typedef struct packed {
    logic [3:0] pal;
    logic       vflip;
    logic       hflip;
    logic [9:0] tile;
  } screen_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    MAP_REQ,
    MAP_WAIT,
    TILE_REQ,
    TILE_WAIT,
    EMIT,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/vram_pixel_unpack.sv
// Picks one pixel out of a fetched tile-row word, honouring hflip and the
// 4bpp/8bpp packing.
module vram_pixel_unpack (
  input  logic [31:0] row_word,
  input  logic [2:0]  fx,
  input  logic        hflip,
  input  logic        mode_8bpp,
  output logic [7:0]  pixel
);

  logic [2:0] n4;
  logic [1:0] n8;

  always_comb begin
    n4 = hflip ? 3'd7 - fx : fx;
    n8 = hflip ? 2'd3 - fx[1:0] : fx[1:0];
    if (mode_8bpp)
      pixel = row_word[{n8, 3'b000} +: 8];
    else
      pixel = {4'd0, row_word[{n4, 2'b00} +: 4]};
  end

endmodule

// File: rtl/vram_bg_text_fetch.sv
// Text-mode BG scanline fetcher: reads map entries and tile rows, streams pixels.
// Define VRAM_FETCH_8BPP_EN to add the color_8bpp port and 8bpp tile support.
module vram_bg_text_fetch
  import gba_vram_pkg::*;
#(
  parameter int LINE_PIXELS = 240,
  parameter int MAP_TILES   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  line_y,
  input  logic [8:0]  scroll_x,
  input  logic [8:0]  scroll_y,
  input  logic [4:0]  map_base,
  input  logic [1:0]  char_base,
`ifdef VRAM_FETCH_8BPP_EN
  input  logic        color_8bpp,
  output logic [7:0]  pix_data,
`else
  output logic [3:0]  pix_data,
`endif
  output logic        vram_rd,
  output logic [13:0] vram_addr,
  input  logic [31:0] vram_q,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [3:0]  pix_pal,
  output logic [7:0]  pix_x,
  output logic        busy,
  output logic        done
);

  fetch_state_t  state, state_nxt;
  logic [7:0]    line_y_r, scroll_x_r, scroll_y_r;
  logic [4:0]    map_base_r;
  logic [1:0]    char_base_r;
  logic          mode_r;
  screen_entry_t entry_r;
  logic [31:0]   row_r;
  logic [7:0]    pix_x_r;
  logic [7:0]    py, px;
  logic [4:0]    tx, ty;
  logic [2:0]    fx, fx_nxt, row;
  logic [31:0]   map_byte, tile_byte;
  logic [7:0]    unpack_px;
  logic          accept, last_pix, start_ok;
  logic          unused_bits;

  assign py       = line_y_r + scroll_y_r;
  assign px       = scroll_x_r + pix_x_r;
  assign tx       = px[7:3] & 5'(MAP_TILES - 1);
  assign ty       = py[7:3] & 5'(MAP_TILES - 1);
  assign fx       = px[2:0];
  assign fx_nxt   = fx + 3'd1;
  assign row      = entry_r.vflip ? 3'd7 - py[2:0] : py[2:0];
  assign start_ok = (state == IDLE) && start;
  assign accept   = (state == EMIT) && pix_ready;
  assign last_pix = (pix_x_r == 8'(LINE_PIXELS - 1));
  assign pix_x    = pix_x_r;

  // Byte addresses; the 14-bit word truncation below gives the 64 KB wrap.
  always_comb begin
    map_byte = 32'(map_base_r) * 32'(MAP_UNIT_BYTES)
             + (32'(ty) * 32'(MAP_TILES) + 32'(tx)) * 32'd2;
    if (mode_r)
      tile_byte = 32'(char_base_r) * 32'(CHAR_UNIT_BYTES)
                + 32'(entry_r.tile) * 32'(2 * TILE4_BYTES)
                + 32'(row) * 32'd8 + (fx[2] ? 32'd4 : 32'd0);
    else
      tile_byte = 32'(char_base_r) * 32'(CHAR_UNIT_BYTES)
                + 32'(entry_r.tile) * 32'(TILE4_BYTES)
                + 32'(row) * 32'd4;
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset)
      pix_x_r <= '0;
    else if (start_ok)
      pix_x_r <= '0;
    else if (accept && !last_pix)
      pix_x_r <= pix_x_r + 8'd1;
  end

  // Datapath registers carry no reset; they are always written before use.
  always_ff @(posedge clock) begin
    if (start_ok) begin
      line_y_r    <= line_y;
      scroll_x_r  <= scroll_x[7:0];
      scroll_y_r  <= scroll_y[7:0];
      map_base_r  <= map_base;
      char_base_r <= char_base;
    end
    if (state == MAP_WAIT)
      entry_r <= tx[0] ? vram_q[31:16] : vram_q[15:0];
    if (state == TILE_WAIT)
      row_r <= vram_q;
  end

`ifdef VRAM_FETCH_8BPP_EN
  always_ff @(posedge clock) begin
    if (start_ok)
      mode_r <= color_8bpp;
  end
`else
  assign mode_r = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    vram_rd   = 1'b0;
    vram_addr = '0;
    pix_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nxt = MAP_REQ;
      end
      MAP_REQ: begin
        vram_rd   = 1'b1;
        vram_addr = 14'(map_byte >> 2);
        state_nxt = MAP_WAIT;
      end
      MAP_WAIT:  state_nxt = TILE_REQ;
      TILE_REQ: begin
        vram_rd   = 1'b1;
        vram_addr = 14'(tile_byte >> 2);
        state_nxt = TILE_WAIT;
      end
      TILE_WAIT: state_nxt = EMIT;
      EMIT: begin
        pix_valid = 1'b1;
        if (accept) begin
          if (last_pix)
            state_nxt = DONE;
          else if (fx_nxt == 3'd0)
            state_nxt = MAP_REQ;
          else if (mode_r && fx_nxt == 3'd4)
            state_nxt = TILE_REQ;
        end
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  vram_pixel_unpack u_unpack (
    .row_word  (row_r),
    .fx        (fx),
    .hflip     (entry_r.hflip),
    .mode_8bpp (mode_r),
    .pixel     (unpack_px)
  );

`ifdef VRAM_FETCH_8BPP_EN
  assign pix_data = (state == EMIT) ? unpack_px : '0;
  assign pix_pal  = (state == EMIT && !mode_r) ? entry_r.pal : '0;
`else
  assign pix_data = (state == EMIT) ? unpack_px[3:0] : '0;
  assign pix_pal  = (state == EMIT) ? entry_r.pal : '0;
`endif

  assign unused_bits = ^{scroll_x[8], scroll_y[8], unpack_px[7:4]};

endmodule

// File: tb/tb_vram_bg_text_fetch.sv
// Scoreboard bench for vram_bg_text_fetch: VRAM model plus expected pixel queue.
module tb_vram_bg_text_fetch;

  logic        clock = 1'b0;
  logic        reset, start, pix_ready;
  logic [7:0]  line_y;
  logic [8:0]  scroll_x, scroll_y;
  logic [4:0]  map_base;
  logic [1:0]  char_base;
  logic        vram_rd;
  logic [13:0] vram_addr;
  logic [31:0] vram_q;
  logic        pix_valid, busy, done;
  logic [3:0]  pix_pal;
  logic [7:0]  pix_x;
`ifdef VRAM_FETCH_8BPP_EN
  logic        color_8bpp;
  logic [7:0]  pix_data;
`else
  logic [3:0]  pix_data;
`endif

  logic [31:0] mem [0:16383];
  int          sx, sy, ly, mb, cb;
  logic [15:0] exp_q [$];
  logic [13:0] rd_log [$];
  int          n_cmp = 0, n_err = 0, done_cnt = 0;
  bit          stalled = 1'b0;
  logic [15:0] held, cur;

  always #5 clock = ~clock;

  vram_bg_text_fetch #(.LINE_PIXELS(240), .MAP_TILES(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .line_y    (line_y),
    .scroll_x  (scroll_x),
    .scroll_y  (scroll_y),
    .map_base  (map_base),
    .char_base (char_base),
`ifdef VRAM_FETCH_8BPP_EN
    .color_8bpp(color_8bpp),
`endif
    .vram_rd   (vram_rd),
    .vram_addr (vram_addr),
    .vram_q    (vram_q),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_pal   (pix_pal),
    .pix_x     (pix_x),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int map_word(int x);
    int px, py;
    px = (sx + x) & 255;
    py = (ly + sy) & 255;
    return (mb * 2048 + ((py >> 3) * 32 + (px >> 3)) * 2) >> 2;
  endfunction

  // Reference pixel {x, colour, palette} straight from the addressing rules.
  function automatic logic [15:0] model_pix(int x);
    int px, py, fx, row, tile, n, tw;
    logic [31:0] w;
    logic [15:0] e;
    logic [3:0]  d;
    px = (sx + x) & 255;
    py = (ly + sy) & 255;
    fx = px & 7;
    w  = mem[14'(map_word(x))];
    e  = (((px >> 3) & 1) == 1) ? w[31:16] : w[15:0];
    tile = int'(e[9:0]);
    row  = e[11] ? 7 - (py & 7) : (py & 7);
    tw   = ((cb * 16384 + tile * 32 + row * 4) % 65536) / 4;
    n    = e[10] ? 7 - fx : fx;
    w    = mem[14'(tw)];
    d    = 4'((w >> (4 * n)) & 32'hF);
    return {8'(x), d, e[15:12]};
  endfunction

  // VRAM model: one-cycle read latency.
  always @(posedge clock)
    if (vram_rd) vram_q <= mem[vram_addr];

  always @(negedge clock) begin
    if (vram_rd) rd_log.push_back(vram_addr);
    if (done) done_cnt++;
    if (!reset && pix_valid) begin
      cur = {pix_x, 4'(pix_data), pix_pal};
      if (stalled) check("stall_hold", 32'(cur), 32'(held));
      if (pix_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("pixel", 32'(cur), 32'(exp_q.pop_front()));
      end
      stalled = !pix_ready;
      held    = cur;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic drive_line(input logic [8:0] scx, input logic [8:0] scy, input logic [7:0] lin,
                            input logic [4:0] mbase, input logic [1:0] cbase);
    sx = int'(scx[7:0]); sy = int'(scy[7:0]); ly = int'(lin); mb = int'(mbase); cb = int'(cbase);
    exp_q.delete();
    for (int x = 0; x < 240; x++) exp_q.push_back(model_pix(x));
    rd_log.delete();
    scroll_x = scx; scroll_y = scy; line_y = lin; map_base = mbase; char_base = cbase;
    pix_ready = 1'b1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("map_rd_strobe", 32'(vram_rd), 32'd1);
  endtask

  task automatic run_line(input logic [8:0] scx, input logic [8:0] scy, input logic [7:0] lin,
                          input logic [4:0] mbase, input logic [1:0] cbase, input bit tog);
    int d0, cyc;
    d0 = done_cnt;
    drive_line(scx, scy, lin, mbase, cbase);
    cyc = 0;
    while (done_cnt == d0 && cyc < 4000) begin
      @(posedge clock); #1;
      if (tog) pix_ready = ~pix_ready;
      cyc++;
    end
    pix_ready = 1'b1;
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (4) @(posedge clock);
    #1;
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vram_rd"}, 32'(vram_rd), 32'd0);
    check({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_pix_pal"}, 32'(pix_pal), 32'd0);
  endtask

  initial begin
    int d0, cyc;
    logic [7:0] x_seen;
    reset = 1'b1; start = 1'b0; pix_ready = 1'b1;
    line_y = '0; scroll_x = '0; scroll_y = '0; map_base = '0; char_base = '0;
`ifdef VRAM_FETCH_8BPP_EN
    color_8bpp = 1'b0;
`endif
    for (int i = 0; i < 16384; i++) mem[i] = $urandom();
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Uniform entry 0x0001, tile 1 row 0 = 0x76543210.
    for (int w = 0; w < 512; w++) mem[w] = 32'h0001_0001;
    mem[14'h1008] = 32'h7654_3210;
    run_line(9'h000, 9'h000, 8'd0, 5'd0, 2'd1, 1'b0);
    check("first_map_rd", 32'(rd_log[0]), 32'h0000);
    check("first_tile_rd", 32'(rd_log[1]), 32'h1008);

    // Horizontal flip.
    for (int w = 0; w < 512; w++) mem[w] = 32'h0401_0401;
    run_line(9'h000, 9'h000, 8'd0, 5'd0, 2'd1, 1'b0);

    // Vertical flip with palette A: row 7 of tile 1.
    for (int w = 0; w < 512; w++) mem[w] = 32'hA801_A801;
    run_line(9'h000, 9'h000, 8'd0, 5'd0, 2'd1, 1'b0);
    check("vflip_tile_rd", 32'(rd_log[1]), 32'h100F);

    // Per-column entries, scroll wrapping past tile column 31; scroll bit 8 ignored.
    for (int w = 0; w < 512; w++)
      mem[w] = {4'((2 * w + 1) & 31), 2'b00, 10'(((2 * w + 1) & 31) + 2),
                4'((2 * w) & 31), 2'b00, 10'(((2 * w) & 31) + 2)};
    run_line(9'h0FD, 9'h113, 8'd5, 5'd0, 2'd1, 1'b0);
    check("wrap_map_rd0", 32'(rd_log[0]), 32'd63);
    check("wrap_map_rd1", 32'(rd_log[2]), 32'd48);

    // Random VRAM and configuration with pix_ready toggling.
    for (int i = 0; i < 16384; i++) mem[i] = $urandom();
    run_line(9'($urandom()), 9'($urandom()), 8'($urandom_range(0, 159)),
             5'($urandom()), 2'($urandom()), 1'b1);

    // Reset during EMIT at pix_x = 100, then a clean restart.
    d0 = done_cnt;
    drive_line(9'h03A, 9'h021, 8'd77, 5'd9, 2'd3);
    cyc = 0;
    x_seen = '0;
    while (cyc < 2000) begin
      @(posedge clock); #1;
      cyc++;
      if (pix_valid && pix_x == 8'd100) begin
        x_seen = pix_x;
        break;
      end
    end
    check("reached_x100", 32'(x_seen), 32'd100);
    reset = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("midline_reset");
    reset = 1'b0;
    exp_q.delete();
    repeat (20) @(posedge clock);
    #1;
    check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
    run_line(9'h03A, 9'h021, 8'd77, 5'd9, 2'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_bg_text_fetch.md
Name: vram_bg_text_fetch

Overview:
- Scanline fetcher for one GBA text-mode background, immediately downstream of the B/C VRAM read port.
- On each start pulse it reads screen-map entries and tile rows from VRAM for one line, then unpacks them into a pixel stream.
- Each pixel is a colour index plus palette bank, passed to the line compositor over a valid/ready handshake.
- Scope: 256x256-pixel map only (32x32 tiles), 4bpp tiles in the base build.

Parameters:
LINE_PIXELS, 240, pixels emitted per line; pix_x counts 0..LINE_PIXELS-1.
MAP_TILES, 32, map width and height in tiles; must be a power of two.

Ports:
clock  in  1  system clock; every register is clocked on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a line fetch when idle.
line_y  in  8  screen line number, 0..159.
scroll_x  in  9  horizontal scroll; only bits [7:0] are used.
scroll_y  in  9  vertical scroll; only bits [7:0] are used.
map_base  in  5  screen-map base in 2 KB units.
char_base  in  2  tile-data base in 16 KB units.
vram_rd  out  1  read strobe.
vram_addr  out  14  32-bit word address into VRAM.
vram_q  in  32  read data; sampled exactly one cycle after vram_rd is asserted.
pix_valid  out  1  pixel available.
pix_ready  in  1  consumer accepts the pixel.
pix_data  out  4  colour index; 0 means transparent.
pix_pal  out  4  palette bank.
pix_x  out  8  screen x of the current pixel.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: state goes to IDLE. vram_rd, pix_valid, busy and done are 0. vram_addr, pix_data, pix_pal and pix_x are 0.
- Inputs are latched on the accepted start. start is ignored while busy.
- Derived values:
  - py = (line_y + scroll_y[7:0]) mod 256.
  - px = (scroll_x[7:0] + pix_x) mod 256.
  - tx = px[7:3], ty = py[7:3].
- Map address:
  - Halfword byte address = map_base*2048 + (ty*32 + tx)*2.
  - vram_addr = that address >> 2.
  - tx[0] selects vram_q[31:16] when 1, vram_q[15:0] when 0.
- Screen entry fields: tile[9:0], hflip[10], vflip[11], pal[15:12].
- Tile row address (4bpp):
  - row = vflip ? 7 - py[2:0] : py[2:0].
  - Byte address = char_base*16384 + tile*32 + row*4, taken mod 64 KB.
  - vram_addr = that address >> 2.
- Pixel select: pixel n (0..7) is word bits [4n+3:4n], with n = hflip ? 7 - fx : fx, where fx = px[2:0].
- FSM states: IDLE, MAP_REQ, MAP_WAIT, TILE_REQ, TILE_WAIT, EMIT, DONE.
- IDLE: on start go to MAP_REQ.
- MAP_REQ: drive vram_rd=1 with the map address for one cycle, then go to MAP_WAIT.
- MAP_WAIT: capture the entry from vram_q, then go to TILE_REQ.
- TILE_REQ: drive vram_rd=1 with the tile row address for one cycle, then go to TILE_WAIT.
- TILE_WAIT: capture the row word, then go to EMIT.
- EMIT:
  - pix_valid=1.
  - On pix_valid && pix_ready, pix_x increments.
  - If pix_x was LINE_PIXELS-1, go to DONE.
  - Otherwise, if the new fx == 0 (tile boundary), go to MAP_REQ.
  - Otherwise stay in EMIT.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- Minimum pipeline cost is 4 fetch cycles per tile. The first tile is partial, starting at fx = scroll_x[2:0].
- Map wrap: tx and ty wrap mod 32, so tile column 31 is followed by column 0.
- Backpressure: while pix_valid && !pix_ready, pix_data, pix_pal and pix_x are held stable. vram_rd stays 0 outside the REQ states.
- Reset mid-line returns to IDLE on the next edge with reset values; no done pulse is produced.

Optional Feature:
- Macro: VRAM_FETCH_8BPP_EN.
- Defined: adds input port color_8bpp (1 bit), latched at start.
  - Tile byte address = char_base*16384 + tile*64 + row*8 + (fx[2] ? 4 : 0).
  - Pixel n is byte bits [8n+7:8n] within the selected word, with n = fx[1:0] or its hflip mirror.
  - pix_data widens to 8 bits and pix_pal is driven 0.
  - A re-fetch (TILE_REQ) also occurs on fx transitions 3->4 and 7->0.
- Undefined: no color_8bpp port; pix_data is 4 bits; 4bpp behaviour only.

Decomposition:
- Shared package gba_vram_pkg holds:
  - the screen-entry packed struct (tile, hflip, vflip, pal);
  - the fetch state enum;
  - constants MAP_UNIT_BYTES=2048, CHAR_UNIT_BYTES=16384, TILE4_BYTES=32.
- One combinational sub-module vram_pixel_unpack: selects a pixel from the row word given fx, hflip and mode.

Test Plan:
- Scroll 0, map_base=0, char_base=1, entry 0x0001 everywhere, tile 1 row0 = 0x76543210, line_y=0 -> pixels 0,1,2..7 repeating, 240 pixels then one done pulse; first map read at word 0x0000, first tile read at word 0x1008.
- Same setup, entry 0x0401 (hflip) -> pixels 7,6..0 repeating.
- Entry 0xA801 (vflip, pal 0xA), line_y=0 -> tile row 7 read (word 0x100F); pix_pal=0xA.
- scroll_x=0xFD -> first pixel is fx=5 of tile column 31; the next fetch uses tx=0.
- pix_ready toggling every other cycle -> outputs stable while stalled; all 240 pixels delivered in order, pix_x increments by 1 per accept.
- Reset asserted during EMIT at pix_x=100 -> next cycle pix_valid=0, busy=0, no done; a new start restarts at pix_x=0.
